// File: rtl/adam_mem_apb_bridge.sv
// APB slave to single-cycle SRAM request bridge.
// Range/alignment checks each access and strobes one mem request.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_psel .. i_pwdata      APB request side
//   o_prdata, o_pready,
//   o_pslverr               APB response, decoded from state only
//   o_mem_req .. o_mem_wdata registered SRAM request
//   i_mem_rdata             SRAM read data, valid cycle after req
//
// Optional feature: ADAM_MEM_APB_BRIDGE_RDATA_REG_EN adds a CAPT
// state that registers i_mem_rdata before the response cycle.

module adam_mem_apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int SIZE       = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic                  i_pwrite,
  input  logic [STRB_WIDTH-1:0] i_pstrb,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [STRB_WIDTH-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef ADAM_MEM_APB_BRIDGE_RDATA_REG_EN
  localparam logic [1:0] S_CAPT = 2'd3;
`endif

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'(STRB_WIDTH - 1);
  // One extra bit so SIZE may equal 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] SIZE_LIM =
    (ADDR_WIDTH + 1)'(SIZE);

  logic [1:0]            r_state;
  logic                  r_err_q;
  logic                  r_we_q;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [STRB_WIDTH-1:0] r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_start;
  logic                  w_err;
  logic                  w_resp;
  logic [DATA_WIDTH-1:0] w_rdata_src;

  assign w_start = i_psel & i_penable;
  assign w_err   = ({1'b0, i_paddr} >= SIZE_LIM) |
                   (|(i_paddr & ALIGN_MASK));

`ifdef ADAM_MEM_APB_BRIDGE_RDATA_REG_EN
  logic [DATA_WIDTH-1:0] r_rdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata_q <= '0;
    end else if (r_state == S_CAPT) begin
      r_rdata_q <= i_mem_rdata;
    end
  end

  assign w_rdata_src = r_rdata_q;
`else
  assign w_rdata_src = i_mem_rdata;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_err_q     <= 1'b0;
      r_we_q      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we_q <= i_pwrite;
            if (w_err) begin
              // Bad access: skip the memory, answer next cycle.
              r_err_q <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err_q     <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= i_paddr;
              r_mem_we    <= i_pwrite;
              r_mem_be    <= i_pwrite ? i_pstrb : '1;
              r_mem_wdata <= i_pwdata;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_mem_req <= 1'b0;
`ifdef ADAM_MEM_APB_BRIDGE_RDATA_REG_EN
          r_state   <= S_CAPT;
`else
          r_state   <= S_RESP;
`endif
        end
`ifdef ADAM_MEM_APB_BRIDGE_RDATA_REG_EN
        S_CAPT: begin
          r_state <= S_RESP;
        end
`endif
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_resp = (r_state == S_RESP);

  // Write echo from the memory is never forwarded.
  always_comb begin
    o_pready  = w_resp;
    o_pslverr = w_resp & r_err_q;
    o_prdata  = '0;
    if (w_resp && !r_we_q && !r_err_q) begin
      o_prdata = w_rdata_src;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_adam_mem_apb_bridge.sv
// Testbench for adam_mem_apb_bridge.
// Table vectors, hand sequences and random traffic vs a byte model.

module tb_adam_mem_apb_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int SIZE = 4096;
`ifdef ADAM_MEM_APB_BRIDGE_RDATA_REG_EN
  localparam int VL = 3;
`else
  localparam int VL = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  adam_mem_apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .STRB_WIDTH(SW), .SIZE(SIZE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_psel(psel), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pstrb(pstrb), .i_pwdata(pwdata),
    .o_prdata(prdata), .o_pready(pready),
    .o_pslverr(pslverr),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // SRAM stand-in: registered read, garbage when not reading.
  logic [31:0] sram [SIZE/4];

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_req && !mem_we)
      mem_rdata <= sram[mem_addr[11:2]];
    else
      mem_rdata <= $urandom;
  end

  // Request / ready monitor.
  int          req_cnt = 0;
  int          rdy_cnt = 0;
  logic [31:0] l_addr, l_wdata;
  logic        l_we;
  logic [3:0]  l_be;

  always @(negedge clk) begin
    if (mem_req) begin
      req_cnt <= req_cnt + 1;
      l_addr  <= mem_addr;
      l_we    <= mem_we;
      l_be    <= mem_be;
      l_wdata <= mem_wdata;
    end
    if (pready) rdy_cnt <= rdy_cnt + 1;
  end

  // Transfer-level reference: flat byte array.
  logic [7:0] ref_mem [SIZE];

  task automatic model(input logic [31:0] a, input bit w,
                       input logic [3:0] s,
                       input logic [31:0] d,
                       output logic [31:0] rd,
                       output bit er);
    er = (a >= SIZE) || (a % 4 != 0);
    rd = 0;
    if (!er) begin
      for (int b = 0; b < 4; b++) begin
        if (w && s[b]) ref_mem[a + b] = d[8*b +: 8];
        if (!w) rd[8*b +: 8] = ref_mem[a + b];
      end
    end
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One APB transfer; entered and left just after a posedge.
  task automatic xfer(input logic [31:0] a, input bit w,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output logic er, output int lat,
                      output int nreq, output int nrdy);
    int r0, p0;
    bit done;
    r0 = req_cnt; p0 = rdy_cnt; done = 0;
    psel = 1; penable = 0; paddr = a;
    pwrite = w; pstrb = s; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    lat = 0; rd = 0; er = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (pready) begin
        done = 1; rd = prdata; er = pslverr;
      end else lat++;
    end
    if (!done) begin
      n_vec++; n_mis++;
      $display("FAIL timeout: addr %0h no pready", a);
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
    nreq = req_cnt - r0;
    nrdy = rdy_cnt - p0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] ex_rd;
    bit          ex_err;
    int          ex_lat;
    int          ex_req;
    logic [3:0]  ex_be;
  } vec_t;

  vec_t        tv [11];
  logic [31:0] rd, mrd;
  logic        er;
  bit          mer;
  int          lat, nreq, nrdy, r0, p0;
  bit          done;

  initial begin
    tv[0]  = '{1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 0, VL, 1, 4'hF};
    tv[1]  = '{0, 32'h10,   4'h0, 32'h0,
               32'hDEADBEEF, 0, VL, 1, 4'hF};
    tv[2]  = '{1, 32'h10,   4'h2, 32'h0000AB00, 0, 0, VL, 1, 4'h2};
    tv[3]  = '{0, 32'h10,   4'h0, 32'h0,
               32'hDEADABEF, 0, VL, 1, 4'hF};
    tv[4]  = '{0, 32'h1000, 4'hF, 32'h0,        0, 1, 1, 0, 4'h0};
    tv[5]  = '{0, 32'h13,   4'hF, 32'h0,        0, 1, 1, 0, 4'h0};
    tv[6]  = '{1, 32'hFFC,  4'hF, 32'h12345678, 0, 0, VL, 1, 4'hF};
    tv[7]  = '{0, 32'hFFC,  4'h0, 32'h0,
               32'h12345678, 0, VL, 1, 4'hF};
    tv[8]  = '{1, 32'h10,   4'h0, 32'hFFFFFFFF, 0, 0, VL, 1, 4'h0};
    tv[9]  = '{0, 32'h10,   4'h0, 32'h0,
               32'hDEADABEF, 0, VL, 1, 4'hF};
    tv[10] = '{1, 32'h1000, 4'hF, 32'h55AA55AA, 0, 1, 1, 0, 4'h0};

    for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h0;
    for (int i = 0; i < SIZE/4; i++) sram[i] = 32'h0;

    rst_n = 0; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pstrb = 0; pwdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst pready",  pready,    0);
    chk("rst pslverr", pslverr,   0);
    chk("rst prdata",  prdata,    0);
    chk("rst mem_req", mem_req,   0);
    chk("rst addr",    mem_addr,  0);
    chk("rst we",      mem_we,    0);
    chk("rst be",      mem_be,    0);
    chk("rst wdata",   mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Directed table.
    foreach (tv[i]) begin
      model(tv[i].addr, tv[i].wr, tv[i].strb,
            tv[i].wdata, mrd, mer);
      xfer(tv[i].addr, tv[i].wr, tv[i].strb, tv[i].wdata,
           rd, er, lat, nreq, nrdy);
      chk($sformatf("tv%0d prdata", i), rd, tv[i].ex_rd);
      chk($sformatf("tv%0d pslverr", i), er, tv[i].ex_err);
      chk($sformatf("tv%0d latency", i), lat, tv[i].ex_lat);
      chk($sformatf("tv%0d reqs", i), nreq, tv[i].ex_req);
      chk($sformatf("tv%0d readys", i), nrdy, 1);
      if (tv[i].ex_req == 1) begin
        chk($sformatf("tv%0d addr", i), l_addr, tv[i].addr);
        chk($sformatf("tv%0d we", i), l_we, tv[i].wr);
        chk($sformatf("tv%0d be", i), l_be, tv[i].ex_be);
        if (tv[i].wr)
          chk($sformatf("tv%0d wdata", i), l_wdata,
              tv[i].wdata);
      end
    end

    // Reset while a read sits in REQ.
    psel = 1; penable = 0; paddr = 32'h10; pwrite = 0;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
    chk("midrst req before", mem_req, 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst req", mem_req, 0);
    chk("midrst pready", pready, 0);
    chk("midrst addr", mem_addr, 0);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst idle pready", pready, 0);
    end
    @(posedge clk); #1;
    xfer(32'h10, 0, 4'h0, 0, rd, er, lat, nreq, nrdy);
    chk("postrst prdata", rd, 32'hDEADABEF);
    chk("postrst latency", lat, VL);

    // APB select dropped right after the access cycle.
    r0 = req_cnt; p0 = rdy_cnt;
    psel = 1; penable = 0; paddr = 32'hFFC; pwrite = 0;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    done = 0; lat = 1; rd = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (pready) begin done = 1; rd = prdata; end
      else lat++;
    end
    chk("drop done", done, 1);
    chk("drop latency", lat, VL);
    chk("drop prdata", rd, 32'h12345678);
    repeat (4) @(posedge clk);
    #1;
    chk("drop reqs", req_cnt - r0, 1);
    chk("drop readys", rdy_cnt - p0, 1);

    // Random traffic; first 8 valid and back-to-back.
    r0 = req_cnt; p0 = rdy_cnt;
    for (int i = 0; i < 48; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          w;
      int          sel;
      sel = (i < 8) ? 9 : int'($urandom_range(0, 9));
      case (sel)
        0: a = SIZE + $urandom_range(0, 4096);
        1: a = ($urandom_range(0, 1023) * 4)
               + $urandom_range(1, 3);
        2: a = $urandom;
        default: a = $urandom_range(0, 15) * 4
                     + (($urandom_range(0, 1) == 1)
                        ? 32'hFC0 : 32'h0);
      endcase
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      model(a, w, s, d, mrd, mer);
      xfer(a, w, s, d, rd, er, lat, nreq, nrdy);
      chk($sformatf("rnd%0d prdata", i), rd, mrd);
      chk($sformatf("rnd%0d pslverr", i), er, mer);
      chk($sformatf("rnd%0d latency", i), lat,
          mer ? 1 : VL);
      chk($sformatf("rnd%0d reqs", i), nreq, mer ? 0 : 1);
      chk($sformatf("rnd%0d readys", i), nrdy, 1);
      if (i == 7) begin
        chk("b2b reqs", req_cnt - r0, 8);
        chk("b2b readys", rdy_cnt - p0, 8);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
